// File: rtl/sobel_pkg.sv
// sobel_pkg: window geometry, index helper and pixel type shared by the Sobel pipeline stages.
package sobel_pkg;
   localparam int WINDOW_SIZE = 3;
   localparam int WINDOW_PIX  = WINDOW_SIZE * WINDOW_SIZE;
   localparam int PIXEL_W     = 8;
   typedef logic [PIXEL_W-1:0] pixel_t;
   function automatic int win_idx(input int r, input int c);
      return r * WINDOW_SIZE + c;
   endfunction
endpackage

// File: rtl/window3x3_line_ram.sv
// line_ram: one buffered image line; asynchronous read, synchronous write, read-before-write at one address.
module line_ram #(
   parameter int WIDTH_P = 8,
   parameter int DEPTH_P = 640
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH_P)-1:0] addr_i,
   input  logic [WIDTH_P-1:0]         d_i,
   output logic [WIDTH_P-1:0]         q_o
);
   logic [WIDTH_P-1:0] r_mem [DEPTH_P];
   assign q_o = r_mem[addr_i];
   always_ff @(posedge clk_i)
      if (we_i) r_mem[addr_i] <= d_i;
endmodule

// File: rtl/window3x3.sv
// window3x3: streaming 3x3 neighbourhood generator with a single-entry output register.
// Optional WINDOW3X3_PERF_EN adds a saturating backpressure stall counter on stall_cnt_o.
module window3x3
   import sobel_pkg::*;
#(
   parameter int WIDTH_P = PIXEL_W,
   parameter int IMG_W_P = 640,
   parameter int IMG_H_P = 480
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            valid_i,
   output logic                            ready_o,
   input  logic [WIDTH_P-1:0]              gray_i,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic [WINDOW_PIX*WIDTH_P-1:0]   window_o,
   output logic                            last_o
`ifdef WINDOW3X3_PERF_EN
  ,output logic [31:0]                     stall_cnt_o
`endif
);
   localparam int CW = $clog2(IMG_W_P);
   localparam int RW = $clog2(IMG_H_P);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W_P - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H_P - 1);
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [WIDTH_P-1:0] w_a1, w_a0;
   logic [WINDOW_SIZE-1:0][WIDTH_P-1:0] r_cl, r_cm, w_cn;
   logic [WINDOW_PIX*WIDTH_P-1:0] w_win, r_win;
   logic r_valid, r_last, w_acc, w_emit;
   assign ready_o  = ~r_valid | ready_i;
   assign w_acc    = valid_i & ready_o;
   assign w_emit   = w_acc & (r_row >= RW'(2)) & (r_col >= CW'(2));
   assign w_cn     = {gray_i, w_a0, w_a1};
   assign valid_o  = r_valid;
   assign last_o   = r_last;
   assign window_o = r_win;
   line_ram #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) u_line1 (
      .clk_i(clk_i), .we_i(w_acc), .addr_i(r_col), .d_i(w_a0), .q_o(w_a1));
   line_ram #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) u_line0 (
      .clk_i(clk_i), .we_i(w_acc), .addr_i(r_col), .d_i(gray_i), .q_o(w_a0));
   // columns left to right: two stored columns, then the column being accepted
   for (genvar r = 0; r < WINDOW_SIZE; r++) begin : g_r
      for (genvar c = 0; c < WINDOW_SIZE; c++) begin : g_c
         assign w_win[win_idx(r, c)*WIDTH_P +: WIDTH_P] = (c == 0) ? r_cl[r] : (c == 1) ? r_cm[r] : w_cn[r];
      end
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_acc) begin
         r_col <= (r_col == COL_MAX) ? '0 : r_col + 1'b1;
         if (r_col == COL_MAX) r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end
   always_ff @(posedge clk_i)
      if (w_acc) begin
         r_cl <= r_cm;
         r_cm <= w_cn;
      end
   always_ff @(posedge clk_i)
      if (w_emit) r_win <= w_win;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_emit) begin
         r_valid <= 1'b1;
         r_last  <= (r_col == COL_MAX) && (r_row == ROW_MAX);
      end else if (ready_i) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
`ifdef WINDOW3X3_PERF_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_stall <= '0;
      else if (r_valid & ~ready_i & ~&r_stall) r_stall <= r_stall + 32'd1;
   assign stall_cnt_o = r_stall;
`endif
endmodule

// File: tb/tb_window3x3.sv
// tb_window3x3: table-driven and randomized checks of window3x3 against a frame-level window model.
`timescale 1ns/1ps
module tb_window3x3;
   import sobel_pkg::*;
   localparam int W = 4, H = 4, N = W * H, WW = 9 * PIXEL_W;
   typedef logic [WW-1:0] win_t;
   typedef struct {win_t win; logic last;} exp_t;
   typedef struct {int mode; int base; win_t first; win_t last_w;} vec_t;
   logic clk = 0, rst_i = 1, valid_i = 0, ready_i = 1, ready_o, valid_o, last_o;
   pixel_t gray_i = '0;
   win_t window_o;
   logic v3 = 0, rdy3 = 1, ro3, vo3, lo3;
   pixel_t g3 = '0;
   win_t w3;
`ifdef WINDOW3X3_PERF_EN
   logic [31:0] stall_cnt_o, stall3;
`endif
   int n_vec = 0, n_err = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   window3x3 #(.WIDTH_P(PIXEL_W), .IMG_W_P(W), .IMG_H_P(H)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .gray_i(gray_i),
      .valid_o(valid_o), .ready_i(ready_i), .window_o(window_o), .last_o(last_o)
`ifdef WINDOW3X3_PERF_EN
     ,.stall_cnt_o(stall_cnt_o)
`endif
   );

   window3x3 #(.WIDTH_P(PIXEL_W), .IMG_W_P(3), .IMG_H_P(3)) dut3 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(v3), .ready_o(ro3), .gray_i(g3),
      .valid_o(vo3), .ready_i(rdy3), .window_o(w3), .last_o(lo3)
`ifdef WINDOW3X3_PERF_EN
     ,.stall_cnt_o(stall3)
`endif
   );

   task automatic chk(input string name, input win_t act, input win_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: window whose top-left pixel is (r,c) of the frame image
   function automatic win_t model_win(input pixel_t px[N], input int r, input int c);
      win_t w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w[(dr*3+dc)*PIXEL_W +: PIXEL_W] = px[(r+dr)*W + c + dc];
      return w;
   endfunction

   // mode 0: stream, ready high; 1: random valid gaps and ready; 2: stall first window 5 cycles
   task automatic run_frame(input int mode, input pixel_t px[N], output win_t first, output win_t lastw, output int lat);
      int i = 0, cyc = 0, stalled = 0, acc10 = -1, vis = -1;
      logic v, rdy;
      bit got_first = 0;
      exp_t e;
      for (int r = 0; r < H-2; r++)
         for (int c = 0; c < W-2; c++)
            exp_q.push_back(exp_t'{model_win(px, r, c), (r == H-3) && (c == W-3)});
      first = '0;
      lastw = '0;
      while ((i < N || exp_q.size() > 0) && cyc < 2000) begin
         @(negedge clk);
         if (valid_o && vis < 0) vis = cyc;
         v   = (i < N) && (mode != 1 || $urandom_range(0, 3) != 0);
         rdy = (mode == 1) ? ($urandom_range(0, 2) != 0) : !(mode == 2 && valid_o && stalled < 5);
         valid_i = v;
         gray_i  = (i < N) ? px[i] : '0;
         ready_i = rdy;
         #1;
         if (!rdy && valid_o && exp_q.size() > 0) begin
            stalled++;
            chk("stall_hold", window_o, exp_q[0].win);
            chk("stall_ready", ready_o, 0);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("extra_window", valid_o, 0);
            else begin
               e = exp_q.pop_front();
               chk("window", window_o, e.win);
               chk("last", last_o, e.last);
               if (!got_first) first = window_o;
               got_first = 1;
               lastw = window_o;
            end
         end
         if (v && ready_o) begin
            if (i == 10) acc10 = cyc;
            i++;
         end
         cyc++;
      end
      chk("pending", exp_q.size(), 0);
      chk("pixels_in", i, N);
      @(negedge clk);
      valid_i = 0;
      #1;
      chk("no_extra", valid_o, 0);
      lat = vis - acc10;
   endtask

   initial begin
      vec_t tbl[3];
      pixel_t f0[N], f1[N], fr[N];
      win_t fw, lw, w3exp;
      int lat, n3;
      for (int k = 0; k < N; k++) begin
         f0[k] = pixel_t'(k);
         f1[k] = pixel_t'(100 + k);
      end
      tbl[0] = '{0, 0,   {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0},
                         {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}};
      tbl[1] = '{0, 100, {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100},
                         {8'd115, 8'd114, 8'd113, 8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105}};
      tbl[2] = '{2, 0,   tbl[0].first, tbl[0].last_w};
      @(negedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_ready", ready_o, 1);
`ifdef WINDOW3X3_PERF_EN
      chk("rst_stall", stall_cnt_o, 0);
`endif
      rst_i = 0;
      for (int t = 0; t < 3; t++) begin
         if (tbl[t].base == 0) run_frame(tbl[t].mode, f0, fw, lw, lat);
         else run_frame(tbl[t].mode, f1, fw, lw, lat);
         chk("first_win", fw, tbl[t].first);
         chk("last_win", lw, tbl[t].last_w);
         chk("latency", lat, 1);
      end
`ifdef WINDOW3X3_PERF_EN
      chk("stall_cnt", stall_cnt_o, 5);
`endif
      // mid-frame reset while a window is pending
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         valid_i = 1;
         gray_i  = pixel_t'(k);
         ready_i = 1;
      end
      @(negedge clk);
      valid_i = 0;
      ready_i = 0;
      #1;
      chk("pre_rst_valid", valid_o, 1);
      rst_i = 1;
      #1;
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_last", last_o, 0);
      chk("mid_rst_ready", ready_o, 1);
`ifdef WINDOW3X3_PERF_EN
      chk("mid_rst_stall", stall_cnt_o, 0);
`endif
      @(negedge clk);
      rst_i = 0;
      ready_i = 1;
      run_frame(0, f0, fw, lw, lat);
      chk("post_rst_first", fw, tbl[0].first);
      chk("post_rst_last", lw, tbl[0].last_w);
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < N; k++) fr[k] = pixel_t'($urandom);
         run_frame(1, fr, fw, lw, lat);
      end
      // 3x3 image: exactly one window holding the whole frame
      n3 = 0;
      w3exp = '0;
      for (int k = 0; k < 9; k++) w3exp[k*PIXEL_W +: PIXEL_W] = pixel_t'(k);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         v3 = (k < 9);
         g3 = pixel_t'(k);
         #1;
         if (vo3) begin
            n3++;
            chk("win3", w3, w3exp);
            chk("last3", lo3, 1);
         end
      end
      chk("count3", n3, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
